// File: rtl/ddr3_arb_pkg.sv
// Shared types for the DDR3 command arbiter: requester ID and latched command.
// Latency: n/a (types and configuration only).
// Backpressure: n/a.
package ddr3_arb_pkg;

    localparam int ARB_PORTS     = 4;
    localparam int ARB_ADDR_W    = 32;
    localparam int ARB_DATA_W    = 32;
    localparam int ARB_TAG_DEPTH = 16;
    localparam int ARB_ID_W      = $clog2(ARB_PORTS);

    typedef logic [ARB_ID_W-1:0] port_id_t;

    typedef struct packed {
        logic                    write_ena;
        logic [ARB_ADDR_W-1:0]   addr;
        logic [ARB_DATA_W-1:0]   write_data;
        logic [ARB_DATA_W/8-1:0] write_mask;
    } cmd_t;

endpackage

// File: rtl/ddr3_cmd_arbiter_if.sv
// Requester-side and controller-side command signals of the DDR3 arbiter.
// Latency: n/a (wiring only).
// Backpressure: P_CMD_busy per requester, DDR_CMD_busy from the controller.
interface ddr3_cmd_arbiter_if #(
    parameter int PORTS  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [PORTS-1:0]                 P_CMD_ena;
    logic [PORTS-1:0]                 P_CMD_write_ena;
    logic [PORTS-1:0][ADDR_W-1:0]     P_CMD_addr;
    logic [PORTS-1:0][DATA_W-1:0]     P_CMD_write_data;
    logic [PORTS-1:0][DATA_W/8-1:0]   P_CMD_write_mask;
    logic [PORTS-1:0]                 P_CMD_busy;
    logic [PORTS-1:0]                 P_CMD_read_ready;
    logic [DATA_W-1:0]                P_CMD_read_data;

    logic                             DDR_CMD_busy;
    logic                             DDR_CMD_read_ready;
    logic [DATA_W-1:0]                DDR_CMD_read_data;
    logic                             DDR_CMD_ena;
    logic                             DDR_CMD_write_ena;
    logic [ADDR_W-1:0]                DDR_CMD_addr;
    logic [DATA_W-1:0]                DDR_CMD_write_data;
    logic [DATA_W/8-1:0]              DDR_CMD_write_mask;

    logic                             ERR_orphan;

    modport slave (
        input  P_CMD_ena, P_CMD_write_ena, P_CMD_addr, P_CMD_write_data, P_CMD_write_mask,
        input  DDR_CMD_busy, DDR_CMD_read_ready, DDR_CMD_read_data,
        output P_CMD_busy, P_CMD_read_ready, P_CMD_read_data,
        output DDR_CMD_ena, DDR_CMD_write_ena, DDR_CMD_addr, DDR_CMD_write_data, DDR_CMD_write_mask,
        output ERR_orphan
    );

    modport master (
        output P_CMD_ena, P_CMD_write_ena, P_CMD_addr, P_CMD_write_data, P_CMD_write_mask,
        output DDR_CMD_busy, DDR_CMD_read_ready, DDR_CMD_read_data,
        input  P_CMD_busy, P_CMD_read_ready, P_CMD_read_data,
        input  DDR_CMD_ena, DDR_CMD_write_ena, DDR_CMD_addr, DDR_CMD_write_data, DDR_CMD_write_mask,
        input  ERR_orphan
    );

endinterface

// File: rtl/ddr3_arb_tag_fifo.sv
// Synchronous FIFO holding the requester ID of each outstanding read.
// Latency: push visible at head one cycle later; head is read combinationally.
// Backpressure: push while full is accepted only together with a pop; pop while empty is ignored.
module ddr3_arb_tag_fifo #(
    parameter int W     = 2,
    parameter int DEPTH = 16
) (
    input  logic                    core_clk,
    input  logic                    arst_n,
    input  logic                    push_vld,
    input  logic [W-1:0]            push_dat,
    input  logic                    pop_vld,
    output logic [W-1:0]            head_dat,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == FULL_CNT);
        do_pop   = pop_vld & ~empty;
        // A full FIFO still takes a push when the head leaves in the same cycle.
        do_push  = push_vld & (~full | do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_dat = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/ddr3_cmd_arbiter.sv
// Round-robin share of the DDR3 controller command port among PORTS requesters.
// Latency: accept to DDR_CMD_ena 2 cycles; read return to requester 1 cycle; at most one issue per 2 cycles.
// Backpressure: a port is busy while its command is latched or the read-tag FIFO is full.
module ddr3_cmd_arbiter
    import ddr3_arb_pkg::*;
#(
    parameter int PORTS     = ARB_PORTS,
    parameter int ADDR_W    = ARB_ADDR_W,
    parameter int DATA_W    = ARB_DATA_W,
    parameter int TAG_DEPTH = ARB_TAG_DEPTH
) (
    input  logic              CLK,
    input  logic              RST_N,
    ddr3_cmd_arbiter_if.slave bus
);
    localparam int TCW = $clog2(TAG_DEPTH) + 1;
    localparam logic [TCW-1:0] TAG_FULL_CNT = TCW'(TAG_DEPTH);

    logic [PORTS-1:0]  pend_valid_q, pend_valid_d;
    cmd_t              pend_cmd_q [PORTS];
    cmd_t              pend_cmd_d [PORTS];
    port_id_t          last_grant_q, last_grant_d;
    logic              ddr_ena_q, ddr_ena_d;
    cmd_t              ddr_cmd_q, ddr_cmd_d;
    logic [PORTS-1:0]  rd_rdy_q, rd_rdy_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              orphan_q, orphan_d;

    logic              tag_push, tag_full, tag_empty, tag_room;
    port_id_t          tag_head;
    logic [TCW-1:0]    tag_count;
    logic [PORTS-1:0]  p_busy, eligible;
    logic              pick_found, grant;
    port_id_t          winner;

    // First eligible port strictly after 'last' in cyclic order, as {found, id}.
    function automatic logic [ARB_ID_W:0] rr_pick(input logic [PORTS-1:0] elig, input port_id_t last);
        logic [ARB_ID_W:0] res;
        int                idx;
        res = '0;
        for (int k = PORTS; k >= 1; k--) begin
            idx = (int'(last) + k) % PORTS;
            if (elig[idx]) res = {1'b1, port_id_t'(idx)};
        end
        return res;
    endfunction

    always_comb begin
        tag_room = (tag_count != TAG_FULL_CNT);
        p_busy   = pend_valid_q | {PORTS{tag_full}};
        for (int i = 0; i < PORTS; i++) begin
            eligible[i] = pend_valid_q[i] & (pend_cmd_q[i].write_ena | tag_room);
        end
        {pick_found, winner} = rr_pick(eligible, last_grant_q);
        // ddr_ena_q marks the cycle after a grant, which is always left idle.
        grant    = pick_found & ~bus.DDR_CMD_busy & ~ddr_ena_q;
        tag_push = grant & ~pend_cmd_q[winner].write_ena;
    end

    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_cmd_d   = pend_cmd_q;
        last_grant_d = last_grant_q;
        ddr_ena_d    = grant;
        ddr_cmd_d    = ddr_cmd_q;
        rd_rdy_d     = '0;
        rd_data_d    = rd_data_q;
        orphan_d     = orphan_q;
        if (grant) begin
            pend_valid_d[winner] = 1'b0;
            last_grant_d         = winner;
            ddr_cmd_d            = pend_cmd_q[winner];
        end
        for (int i = 0; i < PORTS; i++) begin
            if (bus.P_CMD_ena[i] && !p_busy[i]) begin
                pend_valid_d[i] = 1'b1;
                pend_cmd_d[i]   = '{write_ena:  bus.P_CMD_write_ena[i],
                                    addr:       bus.P_CMD_addr[i],
                                    write_data: bus.P_CMD_write_data[i],
                                    write_mask: bus.P_CMD_write_mask[i]};
            end
        end
        if (bus.DDR_CMD_read_ready) begin
            if (tag_empty) begin
                orphan_d = 1'b1;
            end else begin
                rd_rdy_d[tag_head] = 1'b1;
                rd_data_d          = bus.DDR_CMD_read_data;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pend_valid_q <= '0;
            for (int i = 0; i < PORTS; i++) pend_cmd_q[i] <= '0;
            last_grant_q <= port_id_t'(PORTS - 1);
            ddr_ena_q    <= 1'b0;
            ddr_cmd_q    <= '0;
            rd_rdy_q     <= '0;
            rd_data_q    <= '0;
            orphan_q     <= 1'b0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_cmd_q   <= pend_cmd_d;
            last_grant_q <= last_grant_d;
            ddr_ena_q    <= ddr_ena_d;
            ddr_cmd_q    <= ddr_cmd_d;
            rd_rdy_q     <= rd_rdy_d;
            rd_data_q    <= rd_data_d;
            orphan_q     <= orphan_d;
        end
    end

    ddr3_arb_tag_fifo #(
        .W     (ARB_ID_W),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .core_clk (CLK),
        .arst_n   (RST_N),
        .push_vld (tag_push),
        .push_dat (winner),
        .pop_vld  (bus.DDR_CMD_read_ready),
        .head_dat (tag_head),
        .full     (tag_full),
        .empty    (tag_empty),
        .count    (tag_count)
    );

    assign bus.P_CMD_busy         = p_busy;
    assign bus.P_CMD_read_ready   = rd_rdy_q;
    assign bus.P_CMD_read_data    = rd_data_q;
    assign bus.DDR_CMD_ena        = ddr_ena_q;
    assign bus.DDR_CMD_write_ena  = ddr_cmd_q.write_ena;
    assign bus.DDR_CMD_addr       = ddr_cmd_q.addr;
    assign bus.DDR_CMD_write_data = ddr_cmd_q.write_data;
    assign bus.DDR_CMD_write_mask = ddr_cmd_q.write_mask;
    assign bus.ERR_orphan         = orphan_q;

endmodule

// File: tb/tb_ddr3_cmd_arbiter.sv
// Bench for ddr3_cmd_arbiter: reference model predicts issued commands and routed returns,
// a monitor compares them against the DUT as they appear.
module tb_ddr3_cmd_arbiter;
    localparam int P     = 4;
    localparam int DEPTH = 16;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    ddr3_cmd_arbiter_if #(.PORTS(P), .ADDR_W(32), .DATA_W(32)) bus ();

    ddr3_cmd_arbiter #(.PORTS(P), .ADDR_W(32), .DATA_W(32), .TAG_DEPTH(DEPTH)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
    } exp_cmd_t;

    typedef struct {
        int          port;
        logic [31:0] data;
    } exp_ret_t;

    int checks = 0;
    int errors = 0;

    exp_cmd_t exp_cmd_q[$];
    exp_ret_t exp_ret_q[$];

    // reference model state
    bit          m_pend [P];
    logic        m_we   [P];
    logic [31:0] m_addr [P];
    logic [31:0] m_wdata[P];
    logic [3:0]  m_mask [P];
    int          m_last;
    bit          m_prev;
    int          m_tags[$];
    bit          m_orphan;
    int          cyc = 0;
    bit          md_full;
    int          md_win;
    int          md_c;
    bit          md_busy[P];

    // controller model controls
    int          ctl_due[$];
    logic [31:0] ctl_data[$];
    bit          ctl_hold = 0;
    bit          ctl_rand = 0;
    bit          force_busy = 0;
    int          ctl_lat = 5;
    int          orphan_req_cnt = 0;
    int          orphan_done_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Reference model: evaluated at every edge from the pre-edge inputs.
    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < P; i++) m_pend[i] = 1'b0;
            m_last   = P - 1;
            m_prev   = 1'b0;
            m_orphan = 1'b0;
            m_tags.delete();
            exp_cmd_q.delete();
            exp_ret_q.delete();
        end else begin
            cyc++;
            md_full = (m_tags.size() == DEPTH);
            for (int i = 0; i < P; i++) md_busy[i] = m_pend[i] || md_full;
            md_win = -1;
            if (!bus.DDR_CMD_busy && !m_prev) begin
                for (int k = 1; k <= P; k++) begin
                    md_c = (m_last + k) % P;
                    if (md_win < 0 && m_pend[md_c] && (m_we[md_c] || !md_full)) md_win = md_c;
                end
            end
            if (bus.DDR_CMD_read_ready) begin
                if (m_tags.size() > 0) exp_ret_q.push_back('{m_tags.pop_front(), bus.DDR_CMD_read_data});
                else m_orphan = 1'b1;
            end
            if (md_win >= 0) begin
                exp_cmd_q.push_back('{m_we[md_win], m_addr[md_win], m_wdata[md_win], m_mask[md_win]});
                m_pend[md_win] = 1'b0;
                m_last = md_win;
                if (!m_we[md_win]) m_tags.push_back(md_win);
            end
            m_prev = (md_win >= 0);
            for (int i = 0; i < P; i++) begin
                if (bus.P_CMD_ena[i] && !md_busy[i]) begin
                    m_pend[i]  = 1'b1;
                    m_we[i]    = bus.P_CMD_write_ena[i];
                    m_addr[i]  = bus.P_CMD_addr[i];
                    m_wdata[i] = bus.P_CMD_write_data[i];
                    m_mask[i]  = bus.P_CMD_write_mask[i];
                end
            end
        end
    end

    // Monitor: compares DUT outputs against model expectations on the falling edge.
    exp_cmd_t     mon_c;
    exp_ret_t     mon_r;
    logic [P-1:0] mon_busy;
    logic [P-1:0] mon_vec;
    always @(negedge CLK) begin
        if (RST_N) begin
            if (bus.DDR_CMD_ena || exp_cmd_q.size() != 0) begin
                if (exp_cmd_q.size() == 0) begin
                    chk("cmd_unexpected_ena", bus.DDR_CMD_ena, 0);
                end else begin
                    mon_c = exp_cmd_q.pop_front();
                    chk("cmd_ena", bus.DDR_CMD_ena, 1);
                    if (bus.DDR_CMD_ena) begin
                        chk("cmd_write_ena", bus.DDR_CMD_write_ena, mon_c.we);
                        chk("cmd_addr", bus.DDR_CMD_addr, mon_c.addr);
                        chk("cmd_write_data", bus.DDR_CMD_write_data, mon_c.wdata);
                        chk("cmd_write_mask", bus.DDR_CMD_write_mask, mon_c.mask);
                    end
                end
            end
            if (bus.P_CMD_read_ready != '0 || exp_ret_q.size() != 0) begin
                if (exp_ret_q.size() == 0) begin
                    chk("ret_unexpected", bus.P_CMD_read_ready, 0);
                end else begin
                    mon_r = exp_ret_q.pop_front();
                    mon_vec = '0;
                    mon_vec[mon_r.port] = 1'b1;
                    chk("ret_port", bus.P_CMD_read_ready, mon_vec);
                    chk("ret_data", bus.P_CMD_read_data, mon_r.data);
                end
            end
            for (int i = 0; i < P; i++) mon_busy[i] = m_pend[i] || (m_tags.size() == DEPTH);
            chk("p_busy", bus.P_CMD_busy, mon_busy);
            chk("err_orphan", bus.ERR_orphan, m_orphan);
        end
    end

    // Controller model: in-order read returns after a latency, optional busy.
    initial begin
        bus.DDR_CMD_busy       = 1'b0;
        bus.DDR_CMD_read_ready = 1'b0;
        bus.DDR_CMD_read_data  = '0;
        forever begin
            @(negedge CLK);
            bus.DDR_CMD_read_ready = 1'b0;
            if (RST_N && bus.DDR_CMD_ena && !bus.DDR_CMD_write_ena) begin
                ctl_due.push_back(cyc + (ctl_rand ? int'($urandom_range(1, 8)) : ctl_lat));
                ctl_data.push_back(bus.DDR_CMD_addr == 32'h100 ? 32'hDEADBEEF : $urandom);
            end
            if (orphan_done_cnt != orphan_req_cnt) begin
                bus.DDR_CMD_read_ready = 1'b1;
                bus.DDR_CMD_read_data  = 32'h0BAD0BAD;
                orphan_done_cnt++;
            end else if (!ctl_hold && ctl_due.size() != 0 && cyc >= ctl_due[0]) begin
                bus.DDR_CMD_read_ready = 1'b1;
                bus.DDR_CMD_read_data  = ctl_data.pop_front();
                void'(ctl_due.pop_front());
            end
            bus.DDR_CMD_busy = force_busy || (ctl_rand && $urandom_range(0, 3) == 0);
        end
    end

    task automatic tick();
        @(negedge CLK);
        bus.P_CMD_ena = '0;
    endtask

    task automatic issue(input int p, input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        bus.P_CMD_ena[p]        = 1'b1;
        bus.P_CMD_write_ena[p]  = we;
        bus.P_CMD_addr[p]       = a;
        bus.P_CMD_write_data[p] = d;
        bus.P_CMD_write_mask[p] = m;
    endtask

    task automatic wait_not_busy(input int p);
        int n = 0;
        while (bus.P_CMD_busy[p] && n < 200) begin
            tick();
            n++;
        end
        chk("busy_release_timeout", (n < 200), 1);
    endtask

    function automatic bit model_idle();
        bit idle = (exp_cmd_q.size() == 0) && (exp_ret_q.size() == 0) && (ctl_due.size() == 0);
        for (int i = 0; i < P; i++) if (m_pend[i]) idle = 1'b0;
        return idle;
    endfunction

    task automatic wait_drain();
        int n = 0;
        while (!model_idle() && n < 1000) begin
            tick();
            n++;
        end
        chk("drain_timeout", (n < 1000), 1);
        repeat (3) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.P_CMD_ena        = '0;
        bus.P_CMD_write_ena  = '0;
        bus.P_CMD_addr       = '0;
        bus.P_CMD_write_data = '0;
        bus.P_CMD_write_mask = '0;
        repeat (3) tick();
        chk("rst_p_busy", bus.P_CMD_busy, 0);
        chk("rst_p_read_ready", bus.P_CMD_read_ready, 0);
        chk("rst_p_read_data", bus.P_CMD_read_data, 0);
        chk("rst_ddr_ena", bus.DDR_CMD_ena, 0);
        chk("rst_ddr_write_ena", bus.DDR_CMD_write_ena, 0);
        chk("rst_ddr_addr", bus.DDR_CMD_addr, 0);
        chk("rst_ddr_write_data", bus.DDR_CMD_write_data, 0);
        chk("rst_ddr_write_mask", bus.DDR_CMD_write_mask, 0);
        chk("rst_err_orphan", bus.ERR_orphan, 0);
        RST_N = 1'b1;
        tick();

        // single read from port 2
        issue(2, 1'b0, 32'h100, 32'h0, 4'h0);
        wait_drain();

        // all ports at once, two rounds
        for (int r = 0; r < 2; r++) begin
            tick();
            for (int p = 0; p < P; p++) issue(p, p[0], 32'h200 + 32'(r * 16 + p * 4), $urandom, 4'(p + 3));
            wait_drain();
        end

        // controller busy with port 1 pending
        force_busy = 1'b1;
        tick();
        issue(1, 1'b1, 32'h300, 32'hCAFEF00D, 4'hA);
        repeat (10) tick();
        force_busy = 1'b0;
        wait_drain();

        // tag FIFO full: 15 reads from port 0, then ports 0, 1 (read) and 3 (write)
        ctl_hold = 1'b1;
        for (int n = 0; n < 15; n++) begin
            wait_not_busy(0);
            issue(0, 1'b0, 32'h1000 + 32'(n * 4), 32'h0, 4'h0);
            tick();
        end
        wait_not_busy(0);
        wait_not_busy(1);
        wait_not_busy(3);
        issue(1, 1'b0, 32'h2000, 32'h0, 4'h0);
        issue(0, 1'b0, 32'h1040, 32'h0, 4'h0);
        issue(3, 1'b1, 32'h3000, 32'h12345678, 4'h5);
        repeat (12) tick();
        ctl_hold = 1'b0;
        wait_drain();

        // orphan return with the tag FIFO empty
        orphan_req_cnt++;
        repeat (4) tick();
        tick();
        issue(2, 1'b1, 32'h400, 32'h1, 4'h1);
        wait_drain();

        // asynchronous reset with three ports pending
        force_busy = 1'b1;
        tick();
        issue(1, 1'b0, 32'h500, 32'h0, 4'h0);
        issue(2, 1'b1, 32'h504, 32'h2, 4'h2);
        issue(3, 1'b1, 32'h508, 32'h3, 4'h3);
        repeat (3) tick();
        #1 RST_N = 1'b0;
        #1;
        chk("arst_p_busy", bus.P_CMD_busy, 0);
        chk("arst_ddr_ena", bus.DDR_CMD_ena, 0);
        chk("arst_err_orphan", bus.ERR_orphan, 0);
        chk("arst_p_read_ready", bus.P_CMD_read_ready, 0);
        repeat (2) tick();
        RST_N = 1'b1;
        force_busy = 1'b0;
        tick();
        issue(3, 1'b1, 32'h600, 32'h6, 4'h6);
        issue(0, 1'b1, 32'h604, 32'h7, 4'h7);
        wait_drain();

        // randomized traffic with random controller busy and latency
        ctl_rand = 1'b1;
        for (int c = 0; c < 400; c++) begin
            tick();
            for (int p = 0; p < P; p++) begin
                if ($urandom_range(0, 2) == 0 && (!bus.P_CMD_busy[p] || $urandom_range(0, 15) == 0))
                    issue(p, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom));
            end
        end
        ctl_rand = 1'b0;
        tick();
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ddr3_cmd_arbiter.md
# ddr3_cmd_arbiter

Round-robin arbiter that shares the single command port of the DDR3 memory controller between `PORTS` requesters, such as the Wishbone bridge, the display fetch and the blitter. Each requester sees a private, controller-identical command port (`CMD_ena` one-shot, `CMD_busy`, `CMD_read_ready`). The arbiter latches one pending command per port, grants the controller in rotating priority, and records the requester ID of every issued read in a tag FIFO. In-order read returns are routed back to the requester that issued them.

## Interface
- `PORTS`, 4 — number of requesters (2..8).
- `ADDR_W`, 32 — command address width.
- `DATA_W`, 32 — data width; mask width is `DATA_W/8`.
- `TAG_DEPTH`, 16 — read-tag FIFO depth (power of 2); bounds outstanding reads.

Ports:
- `CLK` in 1 — single system clock.
- `RST_N` in 1 — reset; asynchronous, active-low.
- `P_CMD_ena` in `[PORTS]` — per-port one-shot command strobe.
- `P_CMD_write_ena` in `[PORTS]` — 1 = write, 0 = read.
- `P_CMD_addr` in `[PORTS][ADDR_W]` — per-port address.
- `P_CMD_write_data` in `[PORTS][DATA_W]` — per-port write data.
- `P_CMD_write_mask` in `[PORTS][DATA_W/8]` — per-port byte enables.
- `P_CMD_busy` out `[PORTS]` — port cannot accept a command.
- `P_CMD_read_ready` out `[PORTS]` — one-shot; read data valid for this port.
- `P_CMD_read_data` out `DATA_W` — returned read data, common to all ports.
- `DDR_CMD_busy` in 1 — controller busy.
- `DDR_CMD_read_ready` in 1 — controller read data valid, one-shot.
- `DDR_CMD_read_data` in `DATA_W` — controller read data.
- `DDR_CMD_ena`, `DDR_CMD_write_ena`, `DDR_CMD_addr`, `DDR_CMD_write_data`, `DDR_CMD_write_mask` out — command to controller, registered.
- `ERR_orphan` out 1 — sticky; a read return arrived while the tag FIFO was empty.

## Operation
- **Accept:** `P_CMD_ena[i] & !P_CMD_busy[i]` at an edge loads pend_valid[i] and the latch fields for port i. `P_CMD_ena[i]` while busy is dropped; this is a requester protocol violation.
- **Busy:** `P_CMD_busy[i] = pend_valid[i] | tag_full`. It is driven combinationally from registers only.
- **Eligibility:** port i is eligible if pend_valid[i] and (write, or tag FIFO not full).
- **Grant:** when `!DDR_CMD_busy` and any port is eligible, the first eligible port after last_grant (cyclic order) wins.
  - The winner's fields drive the registered `DDR_CMD_*` outputs with `DDR_CMD_ena`=1 for exactly one cycle.
  - pend_valid[winner] is cleared and last_grant becomes winner.
  - At most one grant per cycle. No grant is made in the cycle after a grant; this two-cycle issue spacing lets the controller raise busy.
- **Read issue:** a granted read pushes the winner ID into the tag FIFO in the same edge.
- **Return:** `DDR_CMD_read_ready` pops the FIFO head. The next edge sets `P_CMD_read_data` to `DDR_CMD_read_data` and pulses `P_CMD_read_ready[head]` for one cycle.
  - An empty FIFO on return means no pulse and `ERR_orphan` is set.
- **Push/pop:** a push and a pop in the same cycle are legal; count is unchanged.
- **Reset (any time, including mid-transfer):** all pending latches and FIFO pointers clear, and last_grant is set to `PORTS-1`, so port 0 has first priority.
  - In-flight reads at the controller are the system's responsibility; their returns raise `ERR_orphan`.

## Timing
- Reset values:
  - All `P_CMD_busy`, `P_CMD_read_ready`, `DDR_CMD_ena`, `DDR_CMD_write_ena` and `ERR_orphan` are 0.
  - `DDR_CMD_addr`, `DDR_CMD_write_data`, `DDR_CMD_write_mask` and `P_CMD_read_data` are 0.
- Accept to issue: `P_CMD_ena` at edge N gives `DDR_CMD_ena` high after edge N+1 (2 cycles) if the arbiter is idle and `DDR_CMD_busy` is low.
- Return latency: `DDR_CMD_read_ready` at edge M gives `P_CMD_read_ready` high after edge M, i.e. 1-cycle registered routing.
- `DDR_CMD_busy` is sampled at the grant edge. If busy is high, the command stays pending and `P_CMD_busy[i]` stays 1.
- Throughput: one command per 2 cycles maximum. Reads are limited to `TAG_DEPTH` outstanding.
- A port may re-request on the cycle `P_CMD_busy[i]` falls.

## Structure
- Shared package `ddr3_arb_pkg`: the port-ID type (`$clog2(PORTS)` bits) and a packed command struct {write_ena, addr, write_data, write_mask}.
- Sub-module `ddr3_arb_tag_fifo`: synchronous FIFO, width = ID width, depth `TAG_DEPTH`, with full, empty and count outputs. Simultaneous push and pop must be supported when full or empty.
- Round-robin pick is a function in the arbiter body.

## Test plan
- **Single read:** port 2 reads 0x100, controller returns 0xDEADBEEF 5 cycles later.
  - `DDR_CMD_ena` fires 2 cycles after the request with addr 0x100 and write_ena 0.
  - `P_CMD_read_ready[2]` pulses 1 cycle after return with data 0xDEADBEEF.
- **Simultaneous requests:** all 4 ports pulse `P_CMD_ena` in the same cycle.
  - Issue order is 0,1,2,3, spaced 2 cycles apart.
  - A second round from all ports issues 0,1,2,3 again, since last_grant=3.
- **Controller busy:** `DDR_CMD_busy` is held high for 10 cycles with port 1 pending.
  - No `DDR_CMD_ena` occurs and `P_CMD_busy[1]` stays 1.
  - The issue happens on the first edge with busy low.
- **Tag FIFO full:** `TAG_DEPTH`=16 reads are outstanding from port 0.
  - A 17th read stalls and port 3's write still issues.
  - One return unblocks the read, and routing order is preserved across 17 returns.
- **Orphan return:** `DDR_CMD_read_ready` arrives with the FIFO empty.
  - No `P_CMD_read_ready` pulse; `ERR_orphan` = 1 and stays set until reset.
- **Reset mid-transfer:** `RST_N` is asserted asynchronously with 3 ports pending.
  - All outputs reach reset values immediately and pending commands are discarded.
  - After release, port 0 has first priority.
